// File: rtl/sram_parity_pkg.sv
// Shared types and helpers for the parity-protected SRAM and its background scrubber.
package sram_parity_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;
  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned MAX_DATA_W = 256;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReq,
    StCheck
  } scrub_state_e;

  // Odd parity: data bits plus the stored parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [MAX_DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sram_scrub_arbiter.sv
// Port arbiter for the scrubber: yields to the host, but forces one read slot after
// MAX_DEFER consecutive deferrals.
module sram_scrub_arbiter #(
  parameter int unsigned MAX_DEFER = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in_req,
  input  logic i_host_req,
  output logic o_issue,
  output logic o_host_gnt
);

  localparam int unsigned DW = $clog2(MAX_DEFER + 1);

  logic [DW-1:0] r_defer;
  logic          w_at_limit;

  assign w_at_limit = (r_defer == DW'(MAX_DEFER));
  assign o_issue    = i_in_req & (~i_host_req | w_at_limit);
  assign o_host_gnt = i_host_req & ~o_issue;

  // The count only lives while the scrubber sits in its request state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_defer <= '0;
    end else if (!i_in_req) begin
      r_defer <= '0;
    end else if (!o_issue) begin
      r_defer <= r_defer + 1'b1;
    end
  end

endmodule

// File: rtl/sram_parity_scrubber.sv
// Background odd-parity scrubber for the SRAM read port: walks all word addresses,
// logs failing addresses and keeps a saturating error count.
module sram_parity_scrubber
  import sram_parity_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned MAX_DEFER      = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_scrub_en,
  input  logic              i_clear_count,
  input  logic              i_host_req,
  output logic              o_host_gnt,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_par,
  output logic              o_err_valid,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [CNT_W-1:0]  o_err_count,
  output logic              o_pass_done,
  output logic              o_busy
);

  localparam int unsigned IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [IW-1:0] RELOAD = IW'(SCRUB_INTERVAL - 1);

  scrub_state_e      r_state;
  logic [IW-1:0]     r_interval;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_err_addr;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_pass_done;

  logic w_in_req;
  logic w_issue;
  logic w_par_err;

  assign w_in_req  = (r_state == StReq);
  assign w_par_err = (r_state == StCheck) &&
                     !odd_parity_ok(MAX_DATA_W'(i_mem_rdata), i_mem_par);

  sram_scrub_arbiter #(
    .MAX_DEFER(MAX_DEFER)
  ) u_arbiter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_in_req   (w_in_req),
    .i_host_req (i_host_req),
    .o_issue    (w_issue),
    .o_host_gnt (o_host_gnt)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_interval  <= '0;
      r_addr      <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
      r_pass_done <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      r_pass_done <= 1'b0;

      // A clear coinciding with an error still counts that error.
      if (i_clear_count) begin
        r_err_count <= w_par_err ? CNT_W'(1) : '0;
      end else if (w_par_err && !(&r_err_count)) begin
        r_err_count <= r_err_count + 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (i_scrub_en) begin
            r_state    <= StWait;
            r_interval <= RELOAD;
          end
        end
        StWait: begin
          if (!i_scrub_en) begin
            r_state <= StIdle;
          end else if (r_interval == '0) begin
            r_state <= StReq;
          end else begin
            r_interval <= r_interval - 1'b1;
          end
        end
        StReq: begin
          if (w_issue) begin
            r_state <= StCheck;
          end else if (!i_scrub_en) begin
            r_state <= StIdle;
          end
        end
        StCheck: begin
          if (w_par_err) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
          end
          r_pass_done <= &r_addr;
          r_addr      <= r_addr + 1'b1;
          if (i_scrub_en) begin
            r_state    <= StWait;
            r_interval <= RELOAD;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_mem_re    = w_issue;
  assign o_mem_addr  = r_addr;
  assign o_err_valid = r_err_valid;
  assign o_err_addr  = r_err_addr;
  assign o_err_count = r_err_count;
  assign o_pass_done = r_pass_done;
  assign o_busy      = (r_state != StIdle);

endmodule
